// File: rtl/sram_1r1w_fifo_ctrl.sv
// FIFO controller wrapped around a 0rw1r1w SRAM macro. A 2-entry output buffer
// hides the two-edge read latency, so the FIFO moves one word per cycle in and out.
module sram_1r1w_fifo_ctrl #(
  parameter int DATA_WIDTH = 22,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  csb0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam logic [ADDR_WIDTH:0]   MEM_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] obuf [2];
  logic [DATA_WIDTH-1:0] obuf_n [2];
  logic [1:0]            obuf_cnt, obuf_cnt_n;
  logic                  push, pop, issue;
  logic [2:0]            pending;

  assign in_ready  = !rst && (mem_cnt != MEM_FULL);
  assign push      = in_valid && in_ready;
  assign out_valid = !rst && (obuf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = obuf[0];

  // Buffer slots that will be occupied after this edge; a read is issued only if one stays free.
  assign pending = {1'b0, obuf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign issue   = !rst && (mem_cnt != '0) && (pending < 3'd2);

  assign csb0  = !push;
  assign addr0 = wptr;
  assign din0  = in_data;
  assign csb1  = !issue;
  assign addr1 = rptr;

  assign count = rst ? '0 : ({1'b0, mem_cnt} + (ADDR_WIDTH+2)'(rd_inflight)
                             + (ADDR_WIDTH+2)'(obuf_cnt));

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    obuf_n     = obuf;
    obuf_cnt_n = obuf_cnt;
    if (pop) begin
      obuf_n[0]  = obuf[1];
      obuf_cnt_n = obuf_cnt - 2'd1;
    end
    // Capture lands behind whatever survives the pop, preserving order.
    if (rd_inflight) begin
      obuf_n[obuf_cnt_n[0]] = dout1;
      obuf_cnt_n            = obuf_cnt_n + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      obuf_cnt    <= 2'd0;
    end else begin
      if (push)  wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (issue) rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      rd_inflight <= issue;
      obuf_cnt    <= obuf_cnt_n;
    end
  end

  // NOTE: buffer storage has no reset; obuf_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    obuf <= obuf_n;
  end

endmodule
